// File: rtl/acc_cpu_gen_pkg.sv
// acc_cpu_gen shared definitions: opcodes, FSM states, field widths.
// Optional carry feature is selected with ACC_CPU_CARRY_EN.
package acc_cpu_gen_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_STA = 4'h2;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h3;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h4;
    localparam logic [OPC_W-1:0] OP_AND = 4'h5;
    localparam logic [OPC_W-1:0] OP_NEG = 4'h6;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_ADC = 4'h9;
    localparam logic [OPC_W-1:0] OP_JC  = 4'hA;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/acc_cpu_gen_if.sv
// Single-port memory bus between acc_cpu_gen (master) and memory (slave).
// Memory reads combinationally; writes commit on clk when write && mem_ready.
interface acc_cpu_gen_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              read;
    logic              write;
    logic              mem_ready;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] memoryIn;
    logic [DATA_W-1:0] memoryOut;

    modport master (
        output read, write, address, memoryIn,
        input  mem_ready, memoryOut
    );

    modport slave (
        input  read, write, address, memoryIn,
        output mem_ready, memoryOut
    );
endinterface

// File: rtl/acc_cpu_gen_alu.sv
// Combinational datapath for LDA/ADD/SUB/AND/NEG and, with
// ACC_CPU_CARRY_EN defined, ADC plus the carry output.
module acc_cpu_gen_alu
    import acc_cpu_gen_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [OPC_W-1:0]  op_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] opnd_i,
`ifdef ACC_CPU_CARRY_EN
    input  logic              c_i,
    output logic              c_o,
`endif
    output logic [DATA_W-1:0] res_o
);

    localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

    logic cy;

    always_comb begin
        cy    = 1'b0;
        res_o = acc_i;
        unique case (1'b1)
            (op_i == OP_LDA): res_o = opnd_i;
            (op_i == OP_ADD):
                {cy, res_o} = {1'b0, acc_i} + {1'b0, opnd_i};
            // carry out of acc + ~m + 1 means "no borrow"
            (op_i == OP_SUB):
                {cy, res_o} = {1'b0, acc_i} + {1'b0, ~opnd_i} + ONE;
            (op_i == OP_AND): res_o = acc_i & opnd_i;
            (op_i == OP_NEG): res_o = '0 - opnd_i;
`ifdef ACC_CPU_CARRY_EN
            (op_i == OP_ADC):
                {cy, res_o} = {1'b0, acc_i} + {1'b0, opnd_i}
                            + {{DATA_W{1'b0}}, c_i};
`endif
            default: ;
        endcase
    end

`ifdef ACC_CPU_CARRY_EN
    assign c_o = cy;
`else
    logic unused_cy;
    assign unused_cy = cy;
`endif

endmodule

// File: rtl/acc_cpu_gen.sv
// Multicycle accumulator CPU, parametrised data/address width, wait states.
// Define ACC_CPU_CARRY_EN to add the carry flag with ADC and JC opcodes.
module acc_cpu_gen
    import acc_cpu_gen_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    acc_cpu_gen_if.master     bus,
    output logic              halted,
    output logic [DATA_W-1:0] acc_out
);

    if (DATA_W < ADDR_W + OPC_W) begin : g_width_chk
        $fatal(1, "acc_cpu_gen: DATA_W must be >= ADDR_W+4");
    end

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] wd_q;

    logic [OPC_W-1:0]  op;
    logic [ADDR_W-1:0] opa;
    logic [DATA_W-1:0] alu_res;

    assign op  = ir_q[DATA_W-1 -: OPC_W];
    assign opa = ir_q[ADDR_W-1:0];

    // middle instruction bits carry no meaning
    logic unused_ir;
    assign unused_ir = ^ir_q;

`ifdef ACC_CPU_CARRY_EN
    logic c_q;
    logic alu_c;

    acc_cpu_gen_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i   (op),
        .acc_i  (acc_q),
        .opnd_i (bus.memoryOut),
        .c_i    (c_q),
        .c_o    (alu_c),
        .res_o  (alu_res)
    );
`else
    acc_cpu_gen_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i   (op),
        .acc_i  (acc_q),
        .opnd_i (bus.memoryOut),
        .res_o  (alu_res)
    );
`endif

    always_comb begin
        bus.read     = 1'b0;
        bus.write    = 1'b0;
        bus.address  = '0;
        bus.memoryIn = '0;
        unique case (state_q)
            S_FETCH: begin
                bus.address = pc_q;
                bus.read    = 1'b1;
            end
            S_READ: begin
                bus.address = opa;
                bus.read    = 1'b1;
            end
            S_WRITE: begin
                bus.address  = opa;
                bus.write    = 1'b1;
                bus.memoryIn = wd_q;
            end
            default: ;
        endcase
    end

    assign halted  = (state_q == S_HALT);
    assign acc_out = acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
            wd_q    <= '0;
`ifdef ACC_CPU_CARRY_EN
            c_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: state_q <= S_FETCH;
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir_q    <= bus.memoryOut;
                        pc_q    <= pc_q + 1'b1;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_q <= S_FETCH;
                    unique case (1'b1)
                        (op == OP_JMP): pc_q <= opa;
                        (op == OP_JZ): begin
                            if (acc_q == '0) pc_q <= opa;
                        end
`ifdef ACC_CPU_CARRY_EN
                        (op == OP_JC): begin
                            if (c_q) pc_q <= opa;
                        end
                        (op == OP_ADC): state_q <= S_READ;
`endif
                        (op == OP_HLT): state_q <= S_HALT;
                        (op == OP_STA): begin
                            wd_q    <= acc_q;
                            state_q <= S_WRITE;
                        end
                        (op == OP_LDA || op == OP_ADD ||
                         op == OP_SUB || op == OP_AND ||
                         op == OP_NEG): state_q <= S_READ;
                        default: ;
                    endcase
                end
                S_READ: begin
                    if (bus.mem_ready) begin
                        if (op == OP_NEG) begin
                            wd_q    <= alu_res;
                            state_q <= S_WRITE;
                        end else begin
                            acc_q   <= alu_res;
`ifdef ACC_CPU_CARRY_EN
                            if (op == OP_ADD || op == OP_SUB ||
                                op == OP_ADC)
                                c_q <= alu_c;
`endif
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.mem_ready) state_q <= S_FETCH;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/acc_cpu_gen.md
Name: acc_cpu_gen

Overview:
- Parametrised multicycle accumulator CPU. Next generation of the 8-bit/16-word CPU2 core.
- Generalises data and address width.
- Adds memory wait-state handshake, branch instructions, halt state and an accumulator observation port.
- Sits between a single-port memory (combinational read, clocked write) and the system testbench/top.

Parameters:
DATA_W, 8, data and instruction word width; must be >= ADDR_W+4 (elaboration-time check, fatal if violated)
ADDR_W, 4, memory address width; PC width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
read  output  1  memory read strobe
write  output  1  memory write strobe; memory commits memoryIn at the clk edge where write=1 and mem_ready=1
mem_ready  input  1  memory access complete this cycle; tie 1 for zero-wait memory
memoryOut  input  DATA_W  read data from memory (valid combinationally for current address)
memoryIn  output  DATA_W  write data to memory
address  output  ADDR_W  memory address
halted  output  1  high while in HALT state
acc_out  output  DATA_W  current accumulator value

Behaviour:
- Instruction format:
  - opcode = instr[DATA_W-1 -: 4]
  - operand a = instr[ADDR_W-1:0]
  - bits in between ignored
- Opcodes:
  - 0 NOP
  - 1 LDA: ACC<=M[a]
  - 2 STA: M[a]<=ACC
  - 3 ADD: ACC<=ACC+M[a]
  - 4 SUB: ACC<=ACC-M[a]
  - 5 AND: ACC<=ACC&M[a]
  - 6 NEG: M[a]<=-M[a], two's complement; ACC unchanged
  - 7 JMP: PC<=a
  - 8 JZ: if ACC==0, PC<=a
  - F HLT
  - all others execute as NOP
- Arithmetic is modulo 2^DATA_W; overflow discarded. PC increment wraps modulo 2^ADDR_W (PC max -> 0).
- States: IDLE, FETCH, DECODE, READ, WRITE, HALT.
- Reset:
  - state<=IDLE, PC<=0, ACC<=0, IR<=0, wdata<=0.
  - In IDLE: read=0, write=0, address=0, memoryIn=0, halted=0.
  - IDLE -> FETCH unconditionally on the next edge, so the first fetch is one cycle after reset deasserts.
- FETCH:
  - address=PC, read=1.
  - On an edge with mem_ready: IR<=memoryOut, PC<=PC+1, go to DECODE.
  - Otherwise hold all state and outputs.
- DECODE (no bus activity; read=write=0):
  - NOP/unknown -> FETCH
  - JMP -> PC<=a, FETCH
  - JZ -> conditional PC<=a, FETCH
  - HLT -> HALT
  - STA -> wdata<=ACC, WRITE
  - LDA/ADD/SUB/AND/NEG -> READ
- READ:
  - address=a, read=1.
  - On mem_ready: LDA/ADD/SUB/AND update ACC, go to FETCH; NEG does wdata<=-memoryOut, go to WRITE.
- WRITE:
  - address=a, write=1, memoryIn=wdata.
  - On mem_ready -> FETCH.
- HALT: read=write=0, halted=1; stays until reset.
- Outputs read, write, address and memoryIn are combinational from state/PC/IR/wdata. memoryIn=0 outside WRITE.
- Zero-wait latencies (cycles per instruction): NOP/JMP/JZ 2, LDA/ADD/SUB/AND/STA 3, NEG 4.
- While mem_ready=0, address, read, write and memoryIn are held stable.
- Reset has priority over everything. A WRITE that sees mem_ready=1 on the same edge as reset still commits (memory samples that edge); no further access follows.

Optional Feature:
- Macro ACC_CPU_CARRY_EN.
- Defined:
  - Adds carry register C, reset 0.
  - ADD sets C = carry-out. SUB sets C = carry-out of ACC+~M+1 (1 = no borrow).
  - Opcode 9 ADC: ACC<=ACC+M[a]+C, updates C; 3-cycle timing.
  - Opcode A JC: if C, PC<=a; 2-cycle timing.
- Undefined: no C register; opcodes 9 and A execute as NOP.

Decomposition:
- Package acc_cpu_gen_pkg:
  - 4-bit opcode localparams (OP_NOP..OP_HLT, OP_ADC, OP_JC)
  - state encoding localparams
  - opcode field width constant (4)
- Sub-module acc_cpu_gen_alu: combinational.
  - Inputs: op, ACC, operand, C.
  - Outputs: result, carry.
  - Covers LDA/ADD/SUB/AND/NEG/ADC.

Test Plan:
1. NEG, mem_ready=1, DATA_W=8, ADDR_W=4: M0=0x66, M1=0xF0, M6=0x03 -> M6=0xFD; halted=1 on 7th edge after reset release; no further writes.
2. Load/add/store: M0=0x18, M1=0x39, M2=0x2A, M3=0xF0, M8=0x7F, M9=0x02 -> acc_out=0x81, M10=0x81, halted.
3. Wrap: M8=0xFF, M9=0x02 with program 2 -> ACC=0x01. Separately, M0=0x7F (JMP 15), M15=0x00 -> next fetch address is 0.
4. JZ:
   - M0=0x18, M8=0x00, M1=0x85, M5=0xF0 -> fetch at address 5, then halt.
   - Same with M8=0x01 -> fetch at address 2.
5. Wait states: program 2 with mem_ready low for 3 cycles at every access -> address/read/write stable while low, PC unchanged, final M10=0x81 identical.
6. Reset during WRITE wait (mem_ready=0):
   - Assert reset -> M[a] unchanged.
   - Outputs read/write/address=0 while reset is high.
   - After release, first access is fetch at address 0.
